// File: rtl/wb_copy_master.sv
// Wishbone initiator that copies a block of 32-bit words using one single read and one single write per word.
// Optional bus-cycle timeout enabled by defining WB_COPY_TIMEOUT_EN (limit set by to_cycles).
module wb_copy_master #(
    parameter int lw        = 16,
    parameter int to_cycles = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_start_i,
    input  logic [31:0]   cmd_src_i,
    input  logic [31:0]   cmd_dst_i,
    input  logic [lw-1:0] cmd_len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [lw-1:0] words_o,
    output logic [31:0]   wb_adr_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [3:0]    wb_sel_o,
    output logic [31:0]   wb_dat_o,
    input  logic [31:0]   wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);
    // state | meaning
    // IDLE  | waiting for cmd_start_i
    // RD    | single read of the source word in progress
    // WR    | single write of the captured word in progress
    // GAP   | one idle bus cycle; r_next_wr selects WR or RD afterwards
    // DONE  | one-cycle completion/abort pulse, then back to IDLE
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_GAP, S_DONE} state_t;

    state_t        r_state;
    logic          r_next_wr;
    logic [31:0]   r_src;
    logic [31:0]   r_dst;
    logic [31:0]   r_adr;
    logic [31:0]   r_dat;
    logic [lw-1:0] r_rem;
    logic [lw-1:0] r_words;
    logic          r_cyc;
    logic          r_we;
    logic [3:0]    r_sel;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_in_access;
    logic          w_timeout;
    logic          w_abort;
    logic          w_unused;

    assign w_in_access = (r_state == S_RD) || (r_state == S_WR);
    assign w_unused    = ^{cmd_src_i[1:0], cmd_dst_i[1:0]};

`ifdef WB_COPY_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !w_in_access || wb_ack_i || wb_err_i) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    // An ack arriving in the last allowed cycle still completes the access.
    assign w_timeout = w_in_access && !wb_ack_i && (r_to_cnt == 32'(to_cycles - 1));
`else
    localparam int unused_to_cycles = to_cycles;
    assign w_timeout = 1'b0;
`endif

    assign w_abort = w_in_access && (wb_err_i || w_timeout);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_next_wr <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_rem     <= '0;
            r_words   <= '0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= 4'h0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_err   <= 1'b1;
                r_cyc   <= 1'b0;
                r_we    <= 1'b0;
                r_sel   <= 4'h0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cmd_start_i) begin
                            r_src   <= {cmd_src_i[31:2], 2'b00};
                            r_dst   <= {cmd_dst_i[31:2], 2'b00};
                            r_rem   <= cmd_len_i;
                            r_err   <= 1'b0;
                            r_words <= '0;
                            r_busy  <= 1'b1;
                            if (cmd_len_i == '0) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_cyc   <= 1'b1;
                                r_we    <= 1'b0;
                                r_sel   <= 4'hF;
                                r_adr   <= {cmd_src_i[31:2], 2'b00};
                                r_state <= S_RD;
                            end
                        end
                    end
                    S_RD: begin
                        if (wb_ack_i) begin
                            r_dat     <= wb_dat_i;
                            r_cyc     <= 1'b0;
                            r_sel     <= 4'h0;
                            r_next_wr <= 1'b1;
                            r_state   <= S_GAP;
                        end
                    end
                    S_WR: begin
                        if (wb_ack_i) begin
                            r_cyc     <= 1'b0;
                            r_we      <= 1'b0;
                            r_sel     <= 4'h0;
                            r_src     <= r_src + 32'd4;
                            r_dst     <= r_dst + 32'd4;
                            r_words   <= r_words + lw'(1);
                            r_rem     <= r_rem - lw'(1);
                            r_next_wr <= 1'b0;
                            if (r_rem == lw'(1)) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        r_cyc <= 1'b1;
                        r_sel <= 4'hF;
                        if (r_next_wr) begin
                            r_we    <= 1'b1;
                            r_adr   <= r_dst;
                            r_state <= S_WR;
                        end else begin
                            r_we    <= 1'b0;
                            r_adr   <= r_src;
                            r_state <= S_RD;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // cyc and stb come from one register so they can never disagree.
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = r_we;
    assign wb_sel_o = r_sel;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign err_o    = r_err;
    assign words_o  = r_words;

endmodule

// File: tb/tb_wb_copy_master.sv
// Self-checking bench for wb_copy_master: memory-backed slave with wait states and error injection,
// a word-by-word copy model, a directed vector table, random copies and reset/timeout sequences.
module tb_wb_copy_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src, dst;
    logic [15:0] len;
    logic        busy, done, err;
    logic [15:0] words;
    logic [31:0] adr, dat_o, dat_i;
    logic        cyc, stb, we, ack, berr;
    logic [3:0]  sel;

    always #5 clk = ~clk;

    wb_copy_master #(.lw(16), .to_cycles(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cmd_start_i(start), .cmd_src_i(src),
        .cmd_dst_i(dst), .cmd_len_i(len), .busy_o(busy), .done_o(done), .err_o(err),
        .words_o(words), .wb_adr_o(adr), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
        .wb_sel_o(sel), .wb_dat_o(dat_o), .wb_dat_i(dat_i), .wb_ack_i(ack), .wb_err_i(berr)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave model: 1K-word memory aliased on adr[11:2].
    logic [31:0] mem [0:1023];
    logic [32:0] bus_log [$];
    int  wcnt = 0, waits = 0, rd_count = 0, err_target = -1;
    bit  ack_en = 1'b1, allow_drop = 1'b0, rst_seen = 1'b0;

    always_comb begin
        berr  = 1'b0;
        ack   = 1'b0;
        dat_i = mem[adr[11:2]];
        if (stb && wcnt >= waits) begin
            berr = !we && err_target >= 0 && rd_count == err_target;
            ack  = ack_en && !berr;
        end
    end

    always @(posedge clk) begin
        rst_seen <= rst;
        if (stb && !ack && !berr) wcnt <= wcnt + 1;
        else                      wcnt <= 0;
        if (stb && !we && (ack || berr)) rd_count <= rd_count + 1;
    end

    logic        p_stb = 1'b0, p_we = 1'b0, p_ack = 1'b0, p_err = 1'b0;
    logic [31:0] p_adr = '0;

    always @(negedge clk) begin
        if (stb && (ack || berr)) begin
            bus_log.push_back({we, adr});
            if (we && ack) mem[adr[11:2]] = dat_o;
        end
        check("cyc_eq_stb", cyc, stb);
        if (stb) begin
            check("sel_full", sel, 4'hF);
            check("adr_align", adr[1:0], 2'b00);
        end
        if (p_stb && !p_ack && !p_err && !rst_seen && !allow_drop) begin
            check("stb_steady", {stb, we, adr}, {1'b1, p_we, p_adr});
        end
        p_stb = stb; p_we = we; p_ack = ack; p_err = berr; p_adr = adr;
    end

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          waits;
        int          err_at;     // 0 = none, n = error on the n-th read of this copy
        bit          hold;       // keep cmd_start_i high until done
        int          exp_words;
        bit          exp_err;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] exp_mem [0:1023];
        logic [32:0] exp_log [$];
        logic [31:0] a, d;
        int nw, stb_k, done_k, done_cnt, bad;
        bit ee;
        exp_mem = mem;
        ee = (v.err_at != 0 && v.err_at <= v.len);
        nw = ee ? v.err_at - 1 : v.len;
        for (int i = 0; i < nw; i++) begin
            a = (v.src & ~32'h3) + 32'(4 * i);
            d = (v.dst & ~32'h3) + 32'(4 * i);
            exp_log.push_back({1'b0, a});
            exp_log.push_back({1'b1, d});
            exp_mem[d[11:2]] = exp_mem[a[11:2]];
        end
        if (ee) exp_log.push_back({1'b0, (v.src & ~32'h3) + 32'(4 * nw)});

        waits = v.waits;
        ack_en = 1'b1;
        err_target = (v.err_at != 0) ? rd_count + v.err_at - 1 : -1;
        bus_log.delete();
        @(negedge clk);
        src = v.src; dst = v.dst; len = 16'(v.len); start = 1'b1;
        stb_k = -1; done_k = -1; done_cnt = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check({tag, "_busy_rise"}, busy, 1'b1);
                check({tag, "_err_clear"}, err, 1'b0);
            end
            if (!v.hold) start = 1'b0;
            if (stb && stb_k < 0) stb_k = k;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
                start = 1'b0;
            end
            if (done_k >= 0 && k >= done_k + 4) break;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, done_k >= 0, 1'b1);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_words"}, words, 16'(v.exp_words));
        check({tag, "_err"}, err, v.exp_err);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_log_len"}, bus_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < bus_log.size(); i++)
            check({tag, "_bus_op"}, bus_log[i], exp_log[i]);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) bad++;
        check({tag, "_mem"}, bad, 0);
        if (v.waits == 0 && !ee && v.len > 0)
            check({tag, "_latency"}, done_k - stb_k, 4 * v.len - 1);
        if (v.len == 0) begin
            check({tag, "_len0_lat"}, done_k >= 1 && done_k <= 2, 1'b1);
            check({tag, "_len0_nobus"}, stb_k < 0, 1'b1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cyc"}, cyc, 1'b0);
        check({tag, "_stb"}, stb, 1'b0);
        check({tag, "_we"}, we, 1'b0);
        check({tag, "_sel"}, sel, 4'h0);
        check({tag, "_adr"}, adr, 32'h0);
        check({tag, "_dat"}, dat_o, 32'h0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_words"}, words, 16'h0);
    endtask

    vec_t tbl [7];
    vec_t rv;

    initial begin
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        //            src           dst       len wt err hold words err
        tbl[0] = '{32'h0000_0100, 32'h200, 3, 0, 0, 0, 3, 0};
        tbl[1] = '{32'h0000_0040, 32'h080, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{32'h0000_0100, 32'h300, 4, 0, 2, 0, 1, 1};
        tbl[3] = '{32'h0000_0500, 32'h600, 2, 0, 0, 0, 2, 0};
        tbl[4] = '{32'h0000_0701, 32'h802, 2, 3, 0, 1, 2, 0};
        tbl[5] = '{32'hFFFF_FFF8, 32'h900, 3, 1, 0, 0, 3, 0};
        tbl[6] = '{32'h0000_0010, 32'h014, 3, 0, 0, 0, 3, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset while the first write is on the bus.
        waits = 0; ack_en = 1'b1; err_target = -1;
        @(negedge clk);
        src = 32'h100; dst = 32'h200; len = 16'd3; start = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (stb && we) break;
        end
        check("rst_mid_in_wr", stb && we, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        run_vec(tbl[3], "after_rst");

`ifdef WB_COPY_TIMEOUT_EN
        begin
            int hi;
            ack_en = 1'b0; allow_drop = 1'b1;
            @(negedge clk);
            src = 32'h20; dst = 32'h40; len = 16'd1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            hi = 0;
            for (int k = 0; k < 50 && stb; k++) begin
                hi++;
                @(negedge clk);
            end
            check("to_stb_cycles", hi, 8);
            check("to_stb_low", stb, 1'b0);
            check("to_done", done, 1'b1);
            check("to_err", err, 1'b1);
            @(negedge clk);
            ack_en = 1'b1; allow_drop = 1'b0;
        end
`else
        ack_en = 1'b0;
        @(negedge clk);
        src = 32'h20; dst = 32'h40; len = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (1000) @(negedge clk);
        check("hang_stb_high", stb, 1'b1);
        check("hang_no_err", err, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
`endif

        for (int r = 0; r < 10; r++) begin
            rv.src    = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom)};
            rv.dst    = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom)};
            rv.len    = $urandom_range(0, 6);
            rv.waits  = $urandom_range(0, 3);
            rv.err_at = (rv.len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, rv.len) : 0;
            rv.hold   = 1'($urandom);
            rv.exp_words = (rv.err_at != 0) ? rv.err_at - 1 : rv.len;
            rv.exp_err   = (rv.err_at != 0);
            run_vec(rv, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
